// File: rtl/uart_tx_prescaled.sv
// UART transmitter: start, LSB-first data, optional parity, one stop bit.
// Ports: clk, rst (async low), Prescale, P_DATA, Data_Valid, PAR_EN, PAR_TYP -> TX_OUT, busy.
module uart_tx_prescaled #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            Prescale,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [5:0]            r_edge;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par;
  logic [5:0]            r_p;
  logic                  r_tx;
  logic                  r_busy;

  state_t                w_state;
  logic [5:0]            w_edge;
  logic [BW-1:0]         w_bit;
  logic [5:0]            w_p_eff;
  logic                  w_wrap;
  logic                  w_accept;
  logic                  w_tx;
  logic                  w_busy;

  always_comb begin
    unique case (Prescale)
      6'd8:    w_p_eff = 6'd8;
      6'd32:   w_p_eff = 6'd32;
      default: w_p_eff = 6'd16;
    endcase
  end

  assign w_wrap = (r_edge == (r_p - 6'd1));

  always_comb begin
    w_state  = r_state;
    w_edge   = w_wrap ? 6'd0 : (r_edge + 6'd1);
    w_bit    = r_bit;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_edge = 6'd0;
        w_bit  = '0;
        if (Data_Valid) begin
          w_accept = 1'b1;
          w_state  = S_START;
        end
      end
      S_START: begin
        if (w_wrap) w_state = S_DATA;
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_bit == LAST) begin
            w_bit   = '0;
            w_state = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_wrap) w_state = S_STOP;
      end
      S_STOP: begin
        if (w_wrap) w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
        w_edge  = 6'd0;
        w_bit   = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so TX_OUT stays registered.
  always_comb begin
    w_tx   = 1'b1;
    w_busy = (w_state != S_IDLE);
    unique case (w_state)
      S_START:  w_tx = 1'b0;
      S_DATA:   w_tx = r_data[w_bit];
      S_PARITY: w_tx = r_par;
      default:  w_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_edge   <= 6'd0;
      r_bit    <= '0;
      r_data   <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_p      <= 6'd0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_edge  <= w_edge;
      r_bit   <= w_bit;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
      if (w_accept) begin
        r_data   <= P_DATA;
        r_par_en <= PAR_EN;
        r_par    <= (^P_DATA) ^ PAR_TYP;
        r_p      <= w_p_eff;
      end
    end
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Scoreboard bench for uart_tx_prescaled.
// Stimulus queues expected frames; a monitor checks every cycle of each frame.
module tb_uart_tx_prescaled;

  logic       clk;
  logic       rst;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  typedef struct {
    logic [10:0] bits;
    int          n;
    int          p;
    bit          chk_gap;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total    = 0;
  bit   mon_en   = 0;
  bit   mon_busy = 0;

  uart_tx_prescaled #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Monitor: one comparison per frame bit (all P cycles), plus frame end.
  initial begin
    int   idle_cnt;
    exp_t e;
    bit   ok;
    logic got_tx, got_busy;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        idle_cnt = 0;
        continue;
      end
      if (!busy) begin
        idle_cnt++;
        continue;
      end
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_frame: got busy=1 required busy=0");
        while (busy) @(negedge clk);
        idle_cnt = 1;
        continue;
      end
      e = q.pop_front();
      mon_busy = 1;
      if (e.chk_gap) check("idle_gap", idle_cnt, 1);
      for (int k = 0; k < e.n; k++) begin
        ok = 1;
        got_tx = e.bits[k];
        got_busy = 1'b1;
        for (int c = 0; c < e.p; c++) begin
          if (k > 0 || c > 0) @(negedge clk);
          if (ok && (TX_OUT !== e.bits[k] || busy !== 1'b1)) begin
            ok = 0;
            got_tx = TX_OUT;
            got_busy = busy;
          end
        end
        check($sformatf("bit%0d_tx_busy", k), {30'd0, got_busy, got_tx},
              {30'd0, 1'b1, e.bits[k]});
      end
      @(negedge clk);
      check("frame_end_tx_busy", {30'd0, busy, TX_OUT}, 32'b01);
      idle_cnt = 1;
      mon_busy = 0;
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000 && busy; i++) @(negedge clk);
    if (busy) begin
      total++;
      $display("FAIL wait_idle_timeout: got busy=1 required busy=0");
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] pre, input logic [10:0] bits,
                      input int n, input int p, input bit gap);
    exp_t e;
    wait_idle();
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    Prescale = pre;
    e.bits = bits;
    e.n = n;
    e.p = p;
    e.chk_gap = gap;
    q.push_back(e);
    Data_Valid = 1;
    @(negedge clk);
    Data_Valid = 0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 5000 && (q.size() != 0 || mon_busy || busy); i++)
      @(negedge clk);
    if (q.size() != 0 || mon_busy || busy) begin
      total++;
      $display("FAIL drain_timeout: got %0d frames pending required 0",
               q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int i;
    rst = 1;
    Prescale = 6'd16;
    P_DATA = 8'h00;
    Data_Valid = 0;
    PAR_EN = 0;
    PAR_TYP = 0;
    #2 rst = 0;
    #1 check("reset_tx_busy", {30'd0, busy, TX_OUT}, 32'b01);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("idle_tx_busy", {30'd0, busy, TX_OUT}, 32'b01);

    // Reset in the middle of the data bits of 0xFF.
    P_DATA = 8'hFF;
    Data_Valid = 1;
    @(negedge clk);
    Data_Valid = 0;
    check("accept_tx_busy", {30'd0, busy, TX_OUT}, 32'b10);
    repeat (40) @(negedge clk);
    #2 rst = 0;
    #1 check("midframe_reset_tx_busy", {30'd0, busy, TX_OUT}, 32'b01);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", {30'd0, busy, TX_OUT}, 32'b01);
    mon_en = 1;

    // 0xA5, no parity, P=16
    send(8'hA5, 0, 0, 6'd16, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 16, 0);
    drain();
    // 0x03, even parity (0), P=8
    send(8'h03, 1, 0, 6'd8, {1'b1, 1'b0, 8'h03, 1'b0}, 11, 8, 0);
    drain();
    // 0x07, odd parity (0), P=32; Prescale change mid-frame ignored
    send(8'h07, 1, 1, 6'd32, {1'b1, 1'b0, 8'h07, 1'b0}, 11, 32, 0);
    Prescale = 6'd8;
    PAR_TYP = 0;
    drain();
    // Prescale=12 behaves as 16; second request while busy is dropped
    send(8'h5A, 0, 0, 6'd12, {1'b0, 1'b1, 8'h5A, 1'b0}, 10, 16, 0);
    repeat (40) @(negedge clk);
    P_DATA = 8'hC3;
    Data_Valid = 1;
    @(negedge clk);
    Data_Valid = 0;
    drain();
    repeat (60) @(negedge clk);

    // Continuous Data_Valid, P=8: three frames, one idle cycle apart
    wait_idle();
    P_DATA = 8'h3C;
    PAR_EN = 0;
    Prescale = 6'd8;
    for (int f = 0; f < 3; f++) begin
      exp_t e;
      e.bits = {1'b0, 1'b1, 8'h3C, 1'b0};
      e.n = 10;
      e.p = 8;
      e.chk_gap = (f != 0);
      q.push_back(e);
    end
    Data_Valid = 1;
    for (i = 0; i < 1000 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL continuous_timeout: got %0d pending required 0",
               q.size());
    end
    @(negedge clk);
    Data_Valid = 0;
    drain();
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
